// File: rtl/sig_arbiter_if.sv
// Request/result bus between the MAC array, the arbiter and the shared sigmoid unit.
// Latency: none (wires only).
// Backpressure: requesters hold req until ack; the sigmoid side is paced by sig_rdy.
//
// Signals:
//   req, req_data                  : per-requester request level and flattened MAC outputs
//   ack, res_vld, res_data, res_err: per-requester accept pulse and result return
//   busy                           : arbiter has a transaction in flight
//   sig_mac_rdy, sig_mac_out       : drive the shared sigmoid unit
//   sig_rdy, sig_out               : sigmoid unit handshake and result
// Modports: master = requester/sigmoid side, slave = arbiter.
interface sig_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    res_vld;
  logic [DW-1:0]         res_data;
  logic                  res_err;
  logic                  busy;
  logic                  sig_mac_rdy;
  logic [DW-1:0]         sig_mac_out;
  logic                  sig_rdy;
  logic [DW-1:0]         sig_out;

  modport master (
    output req, req_data, sig_rdy, sig_out,
    input  ack, res_vld, res_data, res_err, busy, sig_mac_rdy, sig_mac_out
  );

  modport slave (
    input  req, req_data, sig_rdy, sig_out,
    output ack, res_vld, res_data, res_err, busy, sig_mac_rdy, sig_mac_out
  );
endinterface

// File: rtl/sig_arbiter.sv
// Round-robin scheduler sharing one sigmoid unit among NUM_REQ neuron MAC outputs.
// Latency: ack 1 cycle after req, res_vld SETTLE+1 cycles after req; one result per SETTLE+2 cycles.
// Backpressure: req is held until ack and ignored outside IDLE; waits on sig_rdy up to TIMEOUT cycles.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : sig_arbiter_if.slave (requests/results towards the MAC array,
//                mac_rdy/mac_out/rdy/out towards the sigmoid unit)
// Build option: define SIG_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// ports and timing are unchanged, the round-robin pointer then stays at its reset value.
module sig_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  sig_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]      r_gnt, w_gnt_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0] r_res_vld, w_res_vld_nxt;
  logic [DW-1:0]      r_res_data, w_res_data_nxt;
  logic               r_res_err, w_res_err_nxt;
  logic               r_mac_rdy, w_mac_rdy_nxt;
  logic [DW-1:0]      r_mac_out, w_mac_out_nxt;

  logic               w_any;
  logic [IW-1:0]      w_sel;
  int                 w_idx;

  // Grant selection. Loops run from the lowest-preference candidate upwards so
  // the last hit (highest preference) is the one kept.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
`ifdef SIG_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = i;
      if (bus.req[IW'(w_idx)]) begin
        w_any = 1'b1;
        w_sel = IW'(w_idx);
      end
    end
`else
    // Search order rr_ptr+1, rr_ptr+2, ..., rr_ptr (mod NUM_REQ); k = NUM_REQ
    // revisits the last winner, so it is examined first and overridden by any other.
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (bus.req[IW'(w_idx)]) begin
        w_any = 1'b1;
        w_sel = IW'(w_idx);
      end
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_gnt_nxt      = r_gnt;
    w_cnt_nxt      = r_cnt;
    w_ack_nxt      = '0;
    w_res_vld_nxt  = '0;
    w_res_err_nxt  = 1'b0;
    w_res_data_nxt = r_res_data;
    w_mac_rdy_nxt  = r_mac_rdy;
    w_mac_out_nxt  = r_mac_out;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ack_nxt     = ONE_HOT0 << w_sel;
          w_mac_out_nxt = bus.req_data[w_sel*DW +: DW];
          w_mac_rdy_nxt = 1'b1;
          w_gnt_nxt     = w_sel;
          w_cnt_nxt     = '0;
`ifndef SIG_ARB_FIXED_PRIO_EN
          w_rr_ptr_nxt  = w_sel;
`endif
          w_state_nxt   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if ((r_cnt >= CW'(SETTLE - 1)) && bus.sig_rdy) begin
          w_res_data_nxt = bus.sig_out;
          w_res_vld_nxt  = ONE_HOT0 << r_gnt;
          w_mac_rdy_nxt  = 1'b0;
          w_state_nxt    = S_DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          // Sigmoid unit never answered: return a zero result flagged as error.
          w_res_data_nxt = '0;
          w_res_err_nxt  = 1'b1;
          w_res_vld_nxt  = ONE_HOT0 << r_gnt;
          w_mac_rdy_nxt  = 1'b0;
          w_state_nxt    = S_DONE;
        end
      end

      S_DONE: begin
        // res_vld/res_err fall back to their defaults; res_data keeps its value.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= IW'(NUM_REQ - 1);
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_res_vld  <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
      r_mac_rdy  <= 1'b0;
      r_mac_out  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_res_vld  <= w_res_vld_nxt;
      r_res_data <= w_res_data_nxt;
      r_res_err  <= w_res_err_nxt;
      r_mac_rdy  <= w_mac_rdy_nxt;
      r_mac_out  <= w_mac_out_nxt;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.res_vld     = r_res_vld;
  assign bus.res_data    = r_res_data;
  assign bus.res_err     = r_res_err;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.sig_mac_rdy = r_mac_rdy;
  assign bus.sig_mac_out = r_mac_out;

endmodule

// File: tb/tb_sig_arbiter.sv
// Bench for sig_arbiter: table of single-requester transactions plus hand
// sequences for simultaneous requests, fairness and reset mid-transaction.
// Results are checked through a scoreboard fed when requests are driven.
module tb_sig_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;

  logic clk;
  logic reset;
  bit   sig_rdy_en;
  int   cyc;
  int   tests;
  int   fails;

  sig_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();

  sig_arbiter #(.NUM_REQ(NR), .DW(DW), .SETTLE(2), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sigmoid stand-in: hard sigmoid 0.5 + x/4 clamped to [0, 1.0] in Q3.12,
  // ready whenever it is being driven (unless stalled by the bench).
  function automatic logic [15:0] sig_model(input logic [15:0] x);
    int v;
    v = 32'sh800 + ($signed(x) >>> 2);
    if (v < 0) v = 0;
    if (v > 32'sh1000) v = 32'sh1000;
    return v[15:0];
  endfunction

  always_comb begin
    bus.sig_out = sig_model(bus.sig_mac_out);
    bus.sig_rdy = sig_rdy_en & bus.sig_mac_rdy;
  end

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Scoreboard
  typedef struct {
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (|bus.res_vld === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: res_vld=0x%0h with nothing expected", bus.res_vld);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_res_vld",  32'(bus.res_vld),  32'(e.vld));
        check("sb_res_data", 32'(bus.res_data), 32'(e.data));
        check("sb_res_err",  32'(bus.res_err),  32'(e.err));
      end
    end
  end

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Table-driven single transactions
  typedef struct {
    int          idx;
    logic [15:0] data;
    bit          rdy_en;
    int          lat;       // ISSUE cycles from ack to result
    logic [15:0] exp_data;
    bit          exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int  t0, n_rdy;
    bit  seen, mac_ok;
    @(posedge clk); #1;
    bus.req_data = '0;
    bus.req_data[v.idx*DW +: DW] = v.data;
    sig_rdy_en = v.rdy_en;
    bus.req = onehot(v.idx);
    sb.push_back('{onehot(v.idx), v.exp_data, v.exp_err});
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.ack !== '0) seen = 1'b1;
    end
    if (!seen) begin
      fail_now("vec_ack");
      bus.req = '0;
      sig_rdy_en = 1'b1;
      return;
    end
    check("vec_ack_val", 32'(bus.ack), 32'(onehot(v.idx)));
    check("vec_ack_lat", 32'(cyc - t0), 32'd1);
    n_rdy = 0;
    mac_ok = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.sig_mac_rdy === 1'b1) begin
        n_rdy++;
        if (bus.sig_mac_out !== v.data) mac_ok = 1'b0;
      end
      if (bus.res_vld !== '0) begin
        seen = 1'b1;
        break;
      end
      if (k == 1) bus.req = '0;  // requester slow to drop req after ack
      @(negedge clk);
    end
    bus.req = '0;
    sig_rdy_en = 1'b1;
    if (!seen) begin
      fail_now("vec_res_vld");
      return;
    end
    check("vec_res_lat",     32'(cyc - t0), 32'(1 + v.lat));
    check("vec_mac_rdy_len", 32'(n_rdy),    32'(v.lat));
    check("vec_mac_out_hold", 32'(mac_ok),  32'd1);
    check("vec_busy_done",   32'(bus.busy), 32'd1);
    @(negedge clk);
    check("vec_vld_clear",  32'(bus.res_vld),  32'd0);
    check("vec_err_clear",  32'(bus.res_err),  32'd0);
    check("vec_busy_idle",  32'(bus.busy),     32'd0);
    check("vec_data_held",  32'(bus.res_data), 32'(v.exp_data));
  endtask

  vec_t tbl[7];

  initial begin
    int n_acks;
    int ack_idx[4];
    int ack_cyc[4];
    int exp_ord[4];
    logic [NR-1:0] pend;

    tests = 0;
    fails = 0;
    cyc = 0;
    sig_rdy_en = 1'b1;
    reset = 1'b1;
    bus.req = '0;
    bus.req_data = '0;

    tbl[0] = '{0, 16'h0000, 1'b1, 2, 16'h0800, 1'b0};
    tbl[1] = '{1, 16'h1000, 1'b1, 2, 16'h0C00, 1'b0};
    tbl[2] = '{2, 16'hF000, 1'b1, 2, 16'h0400, 1'b0};
    tbl[3] = '{0, 16'hE000, 1'b1, 2, 16'h0000, 1'b0};
    tbl[4] = '{1, 16'h3000, 1'b1, 2, 16'h1000, 1'b0};
    tbl[5] = '{2, 16'h2000, 1'b1, 2, 16'h1000, 1'b0};
    tbl[6] = '{3, 16'h0000, 1'b0, 8, 16'h0000, 1'b1};  // timeout, sig_rdy stuck low

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",      32'(bus.ack),         32'd0);
    check("rst_res_vld",  32'(bus.res_vld),     32'd0);
    check("rst_res_err",  32'(bus.res_err),     32'd0);
    check("rst_busy",     32'(bus.busy),        32'd0);
    check("rst_mac_rdy",  32'(bus.sig_mac_rdy), 32'd0);
    check("rst_mac_out",  32'(bus.sig_mac_out), 32'd0);
    check("rst_res_data", 32'(bus.res_data),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);
    drain("tbl_drain");

    // All four requesting at once; each drops req one cycle after its ack.
    @(posedge clk); #1;
    bus.req_data = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
    bus.req = 4'hF;
    sb.push_back('{4'b0001, 16'h0800, 1'b0});
    sb.push_back('{4'b0010, 16'h0C00, 1'b0});
    sb.push_back('{4'b0100, 16'h1000, 1'b0});
    sb.push_back('{4'b1000, 16'h1000, 1'b0});
    n_acks = 0;
    pend = '0;
    for (int k = 0; k < 60 && n_acks < 4; k++) begin
      @(posedge clk); #1;
      bus.req = bus.req & ~pend;
      pend = bus.ack;
      if (bus.ack !== '0) begin
        ack_idx[n_acks] = oh2idx(bus.ack);
        ack_cyc[n_acks] = cyc;
        n_acks++;
      end
    end
    @(posedge clk); #1;
    bus.req = '0;
    check("all4_n_acks", 32'(n_acks), 32'd4);
    for (int i = 0; i < n_acks; i++) begin
      check("all4_order", 32'(ack_idx[i]), 32'(i));
      if (i > 0) check("all4_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
    end
    drain("all4_drain");

    // Fairness: req[0] and req[2] held continuously.
`ifdef SIG_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 2, 0, 2};
`endif
    @(posedge clk); #1;
    bus.req_data = {16'h0000, 16'hF000, 16'h0000, 16'h0000};
    bus.req = 4'b0101;
    for (int i = 0; i < 4; i++)
      sb.push_back('{onehot(exp_ord[i]), (exp_ord[i] == 0) ? 16'h0800 : 16'h0400, 1'b0});
    n_acks = 0;
    for (int k = 0; k < 60 && n_acks < 4; k++) begin
      @(posedge clk); #1;
      if (bus.ack !== '0) begin
        ack_idx[n_acks] = oh2idx(bus.ack);
        n_acks++;
      end
    end
    bus.req = '0;
    check("fair_n_acks", 32'(n_acks), 32'd4);
    for (int i = 0; i < n_acks; i++) check("fair_order", 32'(ack_idx[i]), 32'(exp_ord[i]));
    drain("fair_drain");

    // Reset mid-ISSUE: abort, no result, pointer back to reset value.
    @(posedge clk); #1;
    bus.req_data = {16'h0000, 16'h2000, 16'h1000, 16'h0000};
    bus.req = 4'b0010;
    n_acks = 0;
    for (int k = 0; k < 10 && n_acks == 0; k++) begin
      @(posedge clk); #1;
      if (bus.ack !== '0) n_acks = 1;
    end
    if (n_acks == 0) fail_now("rst_mid_ack");
    else check("rst_mid_ack", 32'(bus.ack), 32'b0010);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_res_vld", 32'(bus.res_vld),     32'd0);
    check("rst_mid_mac_rdy", 32'(bus.sig_mac_rdy), 32'd0);
    check("rst_mid_mac_out", 32'(bus.sig_mac_out), 32'd0);
    check("rst_mid_busy",    32'(bus.busy),        32'd0);
    check("rst_mid_data",    32'(bus.res_data),    32'd0);
    bus.req = 4'b0110;
    sb.push_back('{4'b0010, 16'h0C00, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0;
    n_acks = 0;
    for (int k = 0; k < 10 && n_acks == 0; k++) begin
      @(posedge clk); #1;
      if (bus.ack !== '0) n_acks = 1;
    end
    bus.req = '0;
    if (n_acks == 0) fail_now("rst_regrant");
    else check("rst_regrant", 32'(bus.ack), 32'b0010);
    drain("rst_drain");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
